// File: rtl/imem_arbiter.sv
// Two-port (fetch/debug) arbiter in front of a combinational instruction memory.
// Optional IMEM_MISALIGN_TRAP_EN: misaligned grants respond with err=1, rdata=0.
module imem_arbiter #(
  parameter int unsigned DEPTH_WORDS  = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] MEM_BYTES = AW'(DEPTH_WORDS * 4);
  localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RSP_F = 2'd1;
  localparam logic [1:0] RSP_D = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_cnt;
  logic [AW-1:0] mem_addr_q;
  logic [AW-1:0] gnt_addr;
  logic          any_gnt;
  logic          oob_err;
  logic          mis_err;
  logic          gnt_err;
  logic [31:0]   rsp_word;

  // Fetch wins by default; a starved debug request wins once the limit is reached.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (d_req && ((starve_cnt >= LIMIT) || !f_req)) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  assign any_gnt  = f_gnt | d_gnt;
  assign gnt_addr = d_gnt ? d_addr : f_addr;
  assign oob_err  = (gnt_addr >= MEM_BYTES);

`ifdef IMEM_MISALIGN_TRAP_EN
  assign mis_err = (gnt_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^gnt_addr[1:0];
  assign mis_err = 1'b0;
`endif

  assign gnt_err  = oob_err | mis_err;
  assign rsp_word = gnt_err ? 32'h0000_0000 : mem_inst;

  // Memory sees the granted word address in the grant cycle, else the last one.
  assign mem_addr = any_gnt ? {gnt_addr[AW-1:2], 2'b00} : mem_addr_q;

  always_comb begin
    state_d = IDLE;
    if (f_gnt) begin
      state_d = RSP_F;
    end else if (d_gnt) begin
      state_d = RSP_D;
    end
  end

  assign f_rvalid = (state_q == RSP_F);
  assign d_rvalid = (state_q == RSP_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr;
    end
  end

  // Starvation counter saturates so it can never wrap back below the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (d_req && !d_gnt) begin
      if (starve_cnt != {CW{1'b1}}) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Response capture; the idle port keeps its rdata and reports no error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rdata <= '0;
      d_rdata <= '0;
      f_err   <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      f_err <= f_gnt & gnt_err;
      d_err <= d_gnt & gnt_err;
      if (f_gnt) begin
        f_rdata <= rsp_word;
      end
      if (d_gnt) begin
        d_rdata <= rsp_word;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: grants checked at issue, responses checked by a monitor.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req;
  logic [31:0] f_addr, d_addr;
  logic        f_gnt, d_gnt;
  logic        f_rvalid, d_rvalid;
  logic [31:0] f_rdata, d_rdata;
  logic        f_err, d_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] last_f, last_d, last_maddr;

  imem_arbiter #(.DEPTH_WORDS(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_inst(mem_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA000_0000 ^ (a << 8) ^ a;
  endfunction

  // Instruction memory model
  assign mem_inst = word_of(mem_addr);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (f_rvalid && d_rvalid) begin
        chk("both_rvalid", {f_rvalid, d_rvalid}, 64'd0);
      end else if (f_rvalid || d_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {f_rvalid, d_rvalid}, 64'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_port", f_rvalid ? 64'd1 : 64'd2, 64'(e.port));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          if (e.port == 1) begin
            chk("f_rdata", f_rdata, e.rdata);
            chk("f_err", f_err, e.err);
            chk("d_err_idle", d_err, 64'd0);
            chk("d_rdata_hold", d_rdata, last_d);
            last_f = e.rdata;
          end else begin
            chk("d_rdata", d_rdata, e.rdata);
            chk("d_err", d_err, e.err);
            chk("f_err_idle", f_err, 64'd0);
            chk("f_rdata_hold", f_rdata, last_f);
            last_d = e.rdata;
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        chk("missing_rvalid", 64'd0, 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus; eg: 0 no grant, 1 fetch, 2 debug.
  task automatic step(input logic fr, input logic [31:0] fa, input logic dr,
                      input logic [31:0] da, input int eg);
    logic [31:0] a;
    logic        err;
    rsp_t        e;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
    #2;
    chk("gnt", {f_gnt, d_gnt}, {eg == 1, eg == 2});
    if (eg != 0) begin
      a = (eg == 1) ? fa : da;
      err = (a >= 32'd256);
`ifdef IMEM_MISALIGN_TRAP_EN
      err = err | (a[1:0] != 2'b00);
`endif
      last_maddr = {a[31:2], 2'b00};
      e.port  = eg;
      e.err   = err;
      e.rdata = err ? 32'h0 : word_of(last_maddr);
      e.due   = cyc + 1;
      sb.push_back(e);
    end
    chk("mem_addr", mem_addr, last_maddr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    last_f = '0; last_d = '0; last_maddr = '0;
    rst_n = 1'b0;
    f_req = 1'b1; f_addr = 32'h8; d_req = 1'b1; d_addr = 32'hC;
    #12;
    // Reset state, with both requests asserted
    chk("rst_gnt", {f_gnt, d_gnt}, 64'd0);
    chk("rst_rvalid", {f_rvalid, d_rvalid}, 64'd0);
    chk("rst_err", {f_err, d_err}, 64'd0);
    chk("rst_rdata", {f_rdata, d_rdata}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    rst_n = 1'b1;
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    step(1'b0, 32'h0, 1'b0, 32'h0, 0);
    step(1'b1, 32'd4, 1'b0, 32'h0, 1);          // basic fetch, word 1
    step(1'b0, 32'h0, 1'b1, 32'd20, 2);         // debug alone
    step(1'b1, 32'd252, 1'b1, 32'd8, 1);        // last in-range word, fetch priority
    step(1'b0, 32'h0, 1'b0, 32'h0, 0);          // idle: mem_addr holds
    step(1'b1, 32'd256, 1'b0, 32'h0, 1);        // first out-of-range address
    step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 2);  // debug out of range
    step(1'b1, 32'd86, 1'b0, 32'h0, 1);         // misaligned
    step(1'b0, 32'h0, 1'b1, 32'd41, 2);         // misaligned on debug
    step(1'b0, 32'h0, 1'b0, 32'h0, 0);

    // Starvation: four fetch grants then one debug grant, repeating
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h10 + 32'(4 * i), 1'b1, 32'h80 + 32'(4 * i), (i % 5 == 4) ? 2 : 1);
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, 0);

    // Fetch toggling with debug held
    step(1'b1, 32'd12, 1'b1, 32'd16, 1);
    step(1'b0, 32'd12, 1'b1, 32'd16, 2);
    step(1'b1, 32'd24, 1'b1, 32'd28, 1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 0);

    // Reset asserted mid-cycle while a response is out
    step(1'b1, 32'd4, 1'b0, 32'h0, 1);
    f_req = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    last_f = '0; last_d = '0; last_maddr = '0;
    chk("mid_rst_rvalid", {f_rvalid, d_rvalid}, 64'd0);
    chk("mid_rst_gnt", {f_gnt, d_gnt}, 64'd0);
    chk("mid_rst_data", {f_rdata, d_rdata}, 64'd0);
    chk("mid_rst_err", {f_err, d_err}, 64'd0);
    chk("mid_rst_mem_addr", mem_addr, 64'd0);
    @(posedge clk); #3;
    f_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 0);
    end
    step(1'b1, 32'd8, 1'b0, 32'h0, 1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the instruction memory.
- STARVE_LIMIT, 4, consecutive cycles a debug request may wait before it wins priority (1..15).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch requester wants a read this cycle.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  fetch response valid (one-cycle pulse).
- f_rdata  out  32  fetch response instruction word.
- f_err  out  1  fetch response is an error.
- d_req  in  1  debug/loader read request.
- d_addr  in  32  debug byte address.
- d_gnt  out  1  debug request accepted this cycle (combinational).
- d_rvalid  out  1  debug response valid (one-cycle pulse).
- d_rdata  out  32  debug response word.
- d_err  out  1  debug response is an error.
- mem_addr  out  32  address to Instruction_Memory addr.
- mem_inst  in  32  combinational data from Instruction_Memory inst.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 At most one of f_gnt and d_gnt SHALL be high in any cycle.
REQ-005 A grant SHALL be given only to a requester whose req is high, and one grant SHALL be given every cycle that any req is high.
REQ-006 Default priority SHALL be fetch over debug.
REQ-007 starve_cnt (4 bits) SHALL increment each cycle d_req=1 and d_gnt=0, and clear on d_gnt=1 or d_req=0.
REQ-008 When starve_cnt >= STARVE_LIMIT, debug SHALL take priority over fetch for that cycle.
REQ-009 mem_addr SHALL be {granted_addr[31:2],2'b00} in the grant cycle and SHALL hold its last value when there is no grant.
REQ-010 The granted word SHALL be registered at the clk edge ending the grant cycle, with response fields valid in cycle N+1 for a grant in cycle N (latency 1).
REQ-011 Back-to-back grants SHALL be supported (throughput 1 per cycle), with no backpressure on responses.
REQ-012 The response FSM SHALL have states IDLE, RSP_F and RSP_D:
- Next state is RSP_F on f_gnt, RSP_D on d_gnt, IDLE otherwise.
- x_rvalid SHALL be high only in the matching RSP state.
REQ-013 A request with addr >= DEPTH_WORDS*4 SHALL be granted normally, and its response SHALL carry err=1 and rdata=32'h0000_0000.
REQ-014 rdata of the non-responding port SHALL hold its previous value, and its err SHALL be 0.

Reset
REQ-015 While rst_n=0, the block SHALL hold:
- FSM = IDLE.
- starve_cnt = 0.
- mem_addr = 0.
- All rvalid, err and rdata outputs = 0.
REQ-016 Assertion of rst_n mid-operation SHALL discard any pending response, and no rvalid SHALL appear after reset release without a new grant.
REQ-017 Grants SHALL be suppressed while rst_n=0.

Configuration
REQ-018 The macro IMEM_MISALIGN_TRAP_EN SHALL control misaligned-address handling.
- Defined: a granted request with addr[1:0]!=0 SHALL respond with err=1 and rdata=0, and out-of-range checking still applies.
- Not defined: addr[1:0] SHALL be ignored (word-aligned read), and misalignment SHALL never set err.

Verification
REQ-019 Bench scenario: f_req=1, f_addr=4, d_req=0 -> f_gnt=1 same cycle; next cycle f_rvalid=1, f_rdata=mem word 1, f_err=0.
REQ-020 Bench scenario: f_req=1 and d_req=1 continuously, STARVE_LIMIT=4 -> f_gnt for 4 cycles, d_gnt in cycle 5, f_gnt resumes in cycle 6, pattern repeats.
REQ-021 Bench scenario: f_addr=256 with DEPTH_WORDS=64 -> f_rvalid=1, f_err=1, f_rdata=0 one cycle later.
REQ-022 Bench scenario: f_addr=86 -> with IMEM_MISALIGN_TRAP_EN, f_err=1 and f_rdata=0; without it, f_err=0 and f_rdata=word at 84.
REQ-023 Bench scenario: grant at cycle N, rst_n=0 asynchronously mid-cycle N+1 -> f_rvalid drops immediately, all outputs 0, no rvalid after release until a new req.
REQ-024 Bench scenario: f_req toggles 1,0,1 with d_req=1 -> gnt sequence f, d, f with matching single-cycle rvalid pulses one cycle later.
